// File: rtl/encap_result_uart_if.sv
// Read-port bundle between encap_result_uart (master) and the encap C0/C1/K stores (slave).
// Each store returns the addressed 32-bit word one cycle after its read enable.
interface encap_result_uart_if #(
    parameter int C0_AW = 5
);
    logic              rd_C0;
    logic [C0_AW-1:0]  C0_addr;
    logic [31:0]       C0_out;
    logic              rd_C1;
    logic [2:0]        C1_addr;
    logic [31:0]       C1_out;
    logic              rd_K;
    logic [2:0]        K_addr;
    logic [31:0]       K_out;

    modport master (
        output rd_C0, C0_addr, rd_C1, C1_addr, rd_K, K_addr,
        input  C0_out, C1_out, K_out
    );

    modport slave (
        input  rd_C0, C0_addr, rd_C1, C1_addr, rd_K, K_addr,
        output C0_out, C1_out, K_out
    );
endinterface

// File: rtl/encap_result_uart.sv
// encap_result_uart: drains C0, C1 and K after encapsulation and streams them MSB byte
// first over an 8N1 UART. The next word is fetched while the last byte of the current
// word is on the line, so bytes leave back-to-back.
// Optional build macro ENCAP_UART_FRAME_EN: wraps the payload as 0xA5, payload, XOR checksum.
module encap_result_uart #(
    parameter int parameter_set = 1,
    parameter int CLOCK_FPGA    = 100000000,
    parameter int BAUD_RATE     = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done,
    encap_result_uart_if.master  mem,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int m            = (parameter_set == 1) ? 12 : 13;
    localparam int t            = (parameter_set == 1) ? 64 : (parameter_set == 2) ? 96 :
                                  (parameter_set == 4) ? 119 : 128;
    localparam int C0_WORDS     = (m * t + 31) / 32;
    localparam int C0_AW        = $clog2(C0_WORDS);
    localparam int CLKS_PER_BIT = CLOCK_FPGA / BAUD_RATE;
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam logic [C0_AW-1:0] C0_LAST   = C0_AW'(C0_WORDS - 1);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_REQ, ST_WAIT, ST_LATCH, ST_SEND, ST_CSUM, ST_FINISH
    } state_t;

    localparam logic [1:0] SEC_C0 = 2'd0;
    localparam logic [1:0] SEC_C1 = 2'd1;
    localparam logic [1:0] SEC_K  = 2'd2;

`ifdef ENCAP_UART_FRAME_EN
    localparam state_t ST_FIRST = ST_SYNC;
    localparam state_t ST_TAIL  = ST_CSUM;
`else
    localparam state_t ST_FIRST = ST_REQ;
    localparam state_t ST_TAIL  = ST_FINISH;
`endif

    state_t             state_r, state_next_s;
    logic [1:0]         sect_r, sect_next_s;
    logic [C0_AW-1:0]   c0_addr_r;
    logic [2:0]         c1_addr_r, k_addr_r;
    logic [31:0]        word_r, rd_data_s;
    logic [1:0]         byte_sel_r;
    logic               done_q_r, start_s, sect_last_s, word_end_s;
    logic               rd_c0_r, rd_c1_r, rd_k_r, rd_c0_d_s, rd_c1_d_s, rd_k_d_s;
    logic               busy_r, tx_done_r, uart_tx_r;
    logic               tx_active_r, frame_end_s, load_s, byte_avail_s;
    logic [3:0]         bit_idx_r;
    logic [BW-1:0]      baud_cnt_r;
    logic [9:0]         frame_r;
    logic [7:0]         byte_data_s;
`ifdef ENCAP_UART_FRAME_EN
    logic [7:0]         csum_r;
`endif

    assign start_s     = done & ~done_q_r;
    assign frame_end_s = tx_active_r & (bit_idx_r == 4'd9) & (baud_cnt_r == BAUD_LAST);
    assign load_s      = byte_avail_s & (~tx_active_r | frame_end_s);
    assign word_end_s  = (state_r == ST_SEND) & load_s & (byte_sel_r == 2'd3);

    assign mem.rd_C0   = rd_c0_r;
    assign mem.C0_addr = c0_addr_r;
    assign mem.rd_C1   = rd_c1_r;
    assign mem.C1_addr = c1_addr_r;
    assign mem.rd_K    = rd_k_r;
    assign mem.K_addr  = k_addr_r;
    assign uart_tx     = uart_tx_r;
    assign busy        = busy_r;
    assign tx_done     = tx_done_r;

    // Last word of the current section and the read data of that section
    always_comb begin
        case (sect_r)
            SEC_C0:  begin sect_last_s = (c0_addr_r == C0_LAST); rd_data_s = mem.C0_out; end
            SEC_C1:  begin sect_last_s = (c1_addr_r == 3'd7);    rd_data_s = mem.C1_out; end
            SEC_K:   begin sect_last_s = (k_addr_r == 3'd7);     rd_data_s = mem.K_out;  end
            default: begin sect_last_s = 1'b1;                   rd_data_s = 32'h0;      end
        endcase
    end

    // State register, section pointer and done edge detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            sect_r   <= SEC_C0;
            done_q_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            sect_r   <= sect_next_s;
            done_q_r <= done;
        end
    end

    // Next-state logic: fetch/send loop over C0, C1, K
    always_comb begin
        state_next_s = state_r;
        sect_next_s  = sect_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_FIRST;
                    sect_next_s  = SEC_C0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
`ifdef ENCAP_UART_FRAME_EN
            ST_SYNC:  state_next_s = load_s ? ST_REQ : ST_SYNC;
            ST_CSUM:  state_next_s = load_s ? ST_FINISH : ST_CSUM;
`endif
            ST_REQ:   state_next_s = ST_WAIT;
            ST_WAIT:  state_next_s = ST_LATCH;
            ST_LATCH: state_next_s = ST_SEND;
            ST_SEND: begin
                if (word_end_s && sect_last_s && (sect_r == SEC_K)) begin
                    state_next_s = ST_TAIL;
                    sect_next_s  = SEC_C0;
                end else if (word_end_s && sect_last_s) begin
                    state_next_s = ST_REQ;
                    sect_next_s  = sect_r + 2'd1;
                end else if (word_end_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_FINISH: state_next_s = frame_end_s ? ST_IDLE : ST_FINISH;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: byte offered to the transmitter and next-cycle read enables
    always_comb begin
        byte_avail_s = 1'b0;
        byte_data_s  = 8'h00;
        case (state_r)
            ST_SEND: begin
                byte_avail_s = 1'b1;
                case (byte_sel_r)
                    2'd0:    byte_data_s = word_r[31:24];
                    2'd1:    byte_data_s = word_r[23:16];
                    2'd2:    byte_data_s = word_r[15:8];
                    default: byte_data_s = word_r[7:0];
                endcase
            end
`ifdef ENCAP_UART_FRAME_EN
            ST_SYNC: begin byte_avail_s = 1'b1; byte_data_s = 8'hA5;  end
            ST_CSUM: begin byte_avail_s = 1'b1; byte_data_s = csum_r; end
`endif
            default: begin byte_avail_s = 1'b0; byte_data_s = 8'h00; end
        endcase
        rd_c0_d_s = (state_next_s == ST_REQ) & (sect_next_s == SEC_C0);
        rd_c1_d_s = (state_next_s == ST_REQ) & (sect_next_s == SEC_C1);
        rd_k_d_s  = (state_next_s == ST_REQ) & (sect_next_s == SEC_K);
    end

    // Registered read enables, high only during REQ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_c0_r <= 1'b0;
            rd_c1_r <= 1'b0;
            rd_k_r  <= 1'b0;
        end else begin
            rd_c0_r <= rd_c0_d_s;
            rd_c1_r <= rd_c1_d_s;
            rd_k_r  <= rd_k_d_s;
        end
    end

    // Word addresses, captured word and byte pointer; a section's address returns to 0 when it ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c0_addr_r  <= {C0_AW{1'b0}};
            c1_addr_r  <= 3'd0;
            k_addr_r   <= 3'd0;
            word_r     <= 32'h0;
            byte_sel_r <= 2'd0;
        end else if ((state_r == ST_IDLE) && start_s) begin
            c0_addr_r  <= {C0_AW{1'b0}};
            c1_addr_r  <= 3'd0;
            k_addr_r   <= 3'd0;
            byte_sel_r <= 2'd0;
        end else if (state_r == ST_LATCH) begin
            word_r     <= rd_data_s;
            byte_sel_r <= 2'd0;
        end else if ((state_r == ST_SEND) && load_s) begin
            byte_sel_r <= byte_sel_r + 2'd1;
            if (word_end_s) begin
                case (sect_r)
                    SEC_C0:  c0_addr_r <= sect_last_s ? {C0_AW{1'b0}} : c0_addr_r + {{(C0_AW-1){1'b0}}, 1'b1};
                    SEC_C1:  c1_addr_r <= sect_last_s ? 3'd0 : c1_addr_r + 3'd1;
                    SEC_K:   k_addr_r  <= sect_last_s ? 3'd0 : k_addr_r + 3'd1;
                    default: c0_addr_r <= {C0_AW{1'b0}};
                endcase
            end
        end
    end

`ifdef ENCAP_UART_FRAME_EN
    // Running XOR of every payload byte handed to the transmitter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_r <= 8'h00;
        end else if ((state_r == ST_IDLE) && start_s) begin
            csum_r <= 8'h00;
        end else if ((state_r == ST_SEND) && load_s) begin
            csum_r <= csum_r ^ byte_data_s;
        end
    end
`endif

    // 8N1 transmitter: loads a new frame in the last cycle of the previous stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_active_r <= 1'b0;
            frame_r     <= 10'h3FF;
            bit_idx_r   <= 4'd0;
            baud_cnt_r  <= {BW{1'b0}};
            uart_tx_r   <= 1'b1;
        end else if (load_s) begin
            tx_active_r <= 1'b1;
            frame_r     <= {1'b1, byte_data_s, 1'b0};
            bit_idx_r   <= 4'd0;
            baud_cnt_r  <= {BW{1'b0}};
            uart_tx_r   <= 1'b0;
        end else if (tx_active_r && (baud_cnt_r == BAUD_LAST)) begin
            baud_cnt_r <= {BW{1'b0}};
            if (bit_idx_r == 4'd9) begin
                tx_active_r <= 1'b0;
                uart_tx_r   <= 1'b1;
            end else begin
                bit_idx_r <= bit_idx_r + 4'd1;
                frame_r   <= {1'b1, frame_r[9:1]};
                uart_tx_r <= frame_r[1];
            end
        end else if (tx_active_r) begin
            baud_cnt_r <= baud_cnt_r + {{(BW-1){1'b0}}, 1'b1};
        end else begin
            uart_tx_r <= 1'b1;
        end
    end

    // busy spans start edge to end of last stop bit; tx_done pulses as busy falls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r    <= 1'b0;
            tx_done_r <= 1'b0;
        end else begin
            tx_done_r <= (state_r == ST_FINISH) & frame_end_s;
            if ((state_r == ST_IDLE) && start_s) begin
                busy_r <= 1'b1;
            end else if ((state_r == ST_FINISH) && frame_end_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end
endmodule

// File: tb/tb_encap_result_uart.sv
// Bench for encap_result_uart: set 1, CLKS_PER_BIT = 10. A UART receiver decodes the line,
// and a byte-stream model built from the memory contents supplies the expected frame.
module tb_encap_result_uart;
    localparam int CPB = 10;
`ifdef ENCAP_UART_FRAME_EN
    localparam int EXP_BYTES = 162;
`else
    localparam int EXP_BYTES = 160;
`endif

    typedef struct {
        int       mode;       // 0: C0[0]=11223344, 1: K all ones, 2: random
        bit       chk_ends;
        bit [7:0] exp_first;
        bit [7:0] exp_last;
        bit       extra_edge; // second done edge while busy
    } vec_t;

    logic clk = 1'b0;
    logic rst, done, uart_tx, busy, tx_done;
    encap_result_uart_if #(.C0_AW(5)) mem_if ();

    encap_result_uart #(.parameter_set(1), .CLOCK_FPGA(1000), .BAUD_RATE(100)) dut (
        .clk(clk), .rst(rst), .done(done), .mem(mem_if),
        .uart_tx(uart_tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    logic [31:0] c0_mem [24];
    logic [31:0] c1_mem [8];
    logic [31:0] k_mem  [8];
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];
    int          rd_log [$];
    int          exp_rd [$];
    int          checks = 0, errors = 0;
    int          frame_err = 0, onehot_err = 0, rst_epoch = 0;
    vec_t        vecs [3];

    // Memory stores: registered read, one cycle latency
    always @(posedge clk) begin
        if (mem_if.rd_C0) mem_if.C0_out <= c0_mem[mem_if.C0_addr];
        if (mem_if.rd_C1) mem_if.C1_out <= c1_mem[mem_if.C1_addr];
        if (mem_if.rd_K)  mem_if.K_out  <= k_mem[mem_if.K_addr];
    end

    // Read-request monitor
    always @(negedge clk) begin
        if (rst) begin
            if (int'(mem_if.rd_C0) + int'(mem_if.rd_C1) + int'(mem_if.rd_K) > 1) onehot_err++;
            if (mem_if.rd_C0) rd_log.push_back(int'(mem_if.C0_addr));
            if (mem_if.rd_C1) rd_log.push_back(256 + int'(mem_if.C1_addr));
            if (mem_if.rd_K)  rd_log.push_back(512 + int'(mem_if.K_addr));
        end
    end

    always @(negedge rst) rst_epoch <= rst_epoch + 1;

    // UART receiver sampling mid-bit; bytes cut by a reset are discarded
    int       rx_ep;
    bit       rx_sb_ok;
    logic [7:0] rx_byte;
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && uart_tx === 1'b0) begin
                rx_ep = rst_epoch;
                repeat (CPB / 2) @(negedge clk);
                rx_sb_ok = (uart_tx === 1'b0);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rx_byte[b] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (rx_ep == rst_epoch) begin
                    rx_q.push_back(rx_byte);
                    if (uart_tx !== 1'b1 || !rx_sb_ok) frame_err++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_memories(input int mode);
        for (int i = 0; i < 24; i++) c0_mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) begin c1_mem[i] = 32'h0; k_mem[i] = 32'h0; end
        if (mode == 0) c0_mem[0] = 32'h11223344;
        if (mode == 1) for (int i = 0; i < 8; i++) k_mem[i] = 32'hFFFFFFFF;
        if (mode == 2) begin
            for (int i = 0; i < 24; i++) c0_mem[i] = $urandom;
            for (int i = 0; i < 8; i++) begin c1_mem[i] = $urandom; k_mem[i] = $urandom; end
        end
    endtask

    // Reference: every word MSB byte first, C0 then C1 then K, optionally framed
    task automatic build_expected();
        logic [31:0] words [$];
        logic [7:0]  x;
        exp_q.delete(); exp_rd.delete(); x = 8'h00;
        for (int i = 0; i < 24; i++) begin words.push_back(c0_mem[i]); exp_rd.push_back(i); end
        for (int i = 0; i < 8; i++)  begin words.push_back(c1_mem[i]); exp_rd.push_back(256 + i); end
        for (int i = 0; i < 8; i++)  begin words.push_back(k_mem[i]);  exp_rd.push_back(512 + i); end
        foreach (words[w]) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(8'((words[w] >> (8 * b)) & 32'hFF));
                x = x ^ 8'((words[w] >> (8 * b)) & 32'hFF);
            end
        end
`ifdef ENCAP_UART_FRAME_EN
        exp_q.push_front(8'hA5);
        exp_q.push_back(x);
`endif
    endtask

    task automatic run_transfer(input bit extra_edge);
        int t_fall, t_done, edge_at, busy_low;
        bit got_done;
        rx_q.delete(); rd_log.delete(); frame_err = 0; onehot_err = 0;
        t_fall = -1; t_done = -1; busy_low = 0; got_done = 1'b0;
        edge_at = int'($urandom_range(2000, 12000));
        done = 1'b0; @(negedge clk); done = 1'b1;
        @(negedge clk);
        check("busy_rise", busy, 1);
        for (int cyc = 0; cyc < EXP_BYTES * 10 * CPB + 500 && !got_done; cyc++) begin
            @(negedge clk);
            if (t_fall < 0 && uart_tx === 1'b0) t_fall = cyc;
            if (tx_done === 1'b1) begin
                got_done = 1'b1;
                t_done = cyc;
                check("busy_fall_with_tx_done", busy, 0);
            end else if (busy !== 1'b1) begin
                busy_low++;
            end
            if (extra_edge && cyc == edge_at) done = 1'b0;
            if (extra_edge && cyc == edge_at + 4) done = 1'b1;
        end
        check("tx_done_seen", got_done, 1);
        check("tx_done_timing", t_done - t_fall, EXP_BYTES * 10 * CPB);
        check("busy_held", busy_low, 0);
        @(negedge clk);
        check("tx_done_pulse_width", tx_done, 0);
    endtask

    task automatic idle_check(input string name, input int ncyc);
        int bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || uart_tx !== 1'b1 || tx_done !== 1'b0 ||
                mem_if.rd_C0 !== 1'b0 || mem_if.rd_C1 !== 1'b0 || mem_if.rd_K !== 1'b0) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        int mism, rx_before, waited;
        rst = 1'b0; done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rd", {mem_if.rd_C0, mem_if.rd_C1, mem_if.rd_K}, 0);
        check("rst_addr", {mem_if.C0_addr, mem_if.C1_addr, mem_if.K_addr}, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

`ifdef ENCAP_UART_FRAME_EN
        vecs[0] = '{0, 1'b1, 8'hA5, 8'h44, 1'b0};
        vecs[1] = '{1, 1'b1, 8'hA5, 8'h00, 1'b0};
`else
        vecs[0] = '{0, 1'b1, 8'h11, 8'h00, 1'b0};
        vecs[1] = '{1, 1'b1, 8'h00, 8'hFF, 1'b0};
`endif
        vecs[2] = '{2, 1'b0, 8'h00, 8'h00, 1'b1};

        for (int v = 0; v < 3; v++) begin
            load_memories(vecs[v].mode);
            build_expected();
            run_transfer(vecs[v].extra_edge);
            repeat (3) @(negedge clk);
            check("byte_count", rx_q.size(), exp_q.size());
            mism = 0;
            for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
                if (rx_q[i] !== exp_q[i]) mism++;
            check("payload_bytes", mism, 0);
            if (vecs[v].chk_ends) begin
                check("first_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hXX, vecs[v].exp_first);
                check("last_byte", (rx_q.size() > 0) ? rx_q[rx_q.size() - 1] : 8'hXX, vecs[v].exp_last);
            end
            if (vecs[v].mode == 0 && rx_q.size() >= 5) begin
`ifdef ENCAP_UART_FRAME_EN
                check("c0w0_bytes", {rx_q[1], rx_q[2], rx_q[3], rx_q[4]}, 32'h11223344);
`else
                check("c0w0_bytes", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]}, 32'h11223344);
`endif
            end
            check("stop_start_bits", frame_err, 0);
            check("rd_onehot", onehot_err, 0);
            check("rd_count", rd_log.size(), 40);
            mism = 0;
            for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
                if (rd_log[i] != exp_rd[i]) mism++;
            check("rd_order", mism, 0);
        end

        // done still high after finishing: no retrigger
        idle_check("no_retrigger_done_high", 300);

        // New edge starts a transfer; reset during the first start bit aborts it
        rx_before = rx_q.size();
        done = 1'b0; @(negedge clk); done = 1'b1;
        @(negedge clk);
        check("restart_busy", busy, 1);
        waited = 0;
        while (uart_tx !== 1'b0 && waited < 50) begin @(negedge clk); waited++; end
        check("restart_line_low", uart_tx, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_uart_tx", uart_tx, 1);
        check("abort_busy", busy, 0);
        check("abort_rd", {mem_if.rd_C0, mem_if.rd_C1, mem_if.rd_K}, 0);
        done = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        idle_check("idle_after_abort", 200);
        check("aborted_byte_dropped", rx_q.size(), rx_before);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
